// File: rtl/area_sqrt_if.sv
// Handshake bundle for area_sqrt: area in from the multiplier stage over
// /dav-rfd, root and remainder out to the consumer over /dav-rfd.
interface area_sqrt_if #(
    parameter int W_IN  = 16,
    parameter int W_OUT = W_IN / 2
);
    logic [W_IN-1:0]  data_in;
    logic             dav_in_;
    logic             rfd_in;
    logic [W_OUT-1:0] data_out;
    logic [W_OUT:0]   rem_out;
    logic             dav_out_;
    logic             rfd_out;

    // slave: the sqrt block itself
    modport slave (
        input  data_in, dav_in_, rfd_out,
        output rfd_in, data_out, rem_out, dav_out_
    );

    // master: producer plus consumer environment around the block
    modport master (
        output data_in, dav_in_, rfd_out,
        input  rfd_in, data_out, rem_out, dav_out_
    );
endinterface

// File: rtl/area_sqrt.sv
// Bit-serial restoring integer square root of a W_IN-bit area, one root bit
// per clock, with /dav-rfd handshakes on both sides.
module area_sqrt #(
    parameter int W_IN  = 16,
    parameter int W_OUT = W_IN / 2
) (
    input  logic       clock,
    input  logic       reset_,
    area_sqrt_if.slave bus
);
    localparam int CNT_W = $clog2(W_OUT + 1);

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    state_t             state_q, state_d;
    logic [W_IN-1:0]    rad_q, rad_d;
    logic [W_OUT+1:0]   rem_q, rem_d;
    logic [W_OUT-1:0]   root_q, root_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rfd_in_q, rfd_in_d;
    logic               dav_out_q, dav_out_d;
    logic [W_OUT-1:0]   data_out_q, data_out_d;
    logic [W_OUT:0]     rem_out_q, rem_out_d;

    logic [W_OUT+1:0]   t, d, rem_step;
    logic [W_OUT-1:0]   root_step;
    logic               ge;

    // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
    always_comb begin
        t         = (rem_q << 2) | {{W_OUT{1'b0}}, rad_q[W_IN-1 -: 2]};
        d         = {root_q, 2'b01};
        ge        = (t >= d);
        rem_step  = ge ? (t - d) : t;
        root_step = {root_q[W_OUT-2:0], ge};
    end

    always_comb begin
        state_d    = state_q;
        rad_d      = rad_q;
        rem_d      = rem_q;
        root_d     = root_q;
        count_d    = count_q;
        rfd_in_d   = rfd_in_q;
        dav_out_d  = dav_out_q;
        data_out_d = data_out_q;
        rem_out_d  = rem_out_q;
        case (state_q)
            S0: begin
                if (!bus.dav_in_) begin
                    rad_d    = bus.data_in;
                    rem_d    = '0;
                    root_d   = '0;
                    count_d  = CNT_W'(W_OUT);
                    rfd_in_d = 1'b0;
                    state_d  = S1;
                end
            end
            S1: begin
                rem_d   = rem_step;
                root_d  = root_step;
                rad_d   = rad_q << 2;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    data_out_d = root_step;
                    rem_out_d  = (W_OUT + 1)'(rem_step);
                    state_d    = S2;
                end
            end
            S2: begin
                if (bus.rfd_out) begin
                    dav_out_d = 1'b0;
                    state_d   = S3;
                end
            end
            S3: begin
                // Both sides must have closed their handshakes before re-arming.
                if (bus.dav_in_ && !bus.rfd_out) begin
                    dav_out_d = 1'b1;
                    rfd_in_d  = 1'b1;
                    state_d   = S0;
                end
            end
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q    <= S0;
            rfd_in_q   <= 1'b1;
            dav_out_q  <= 1'b1;
            data_out_q <= '0;
            rem_out_q  <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            rfd_in_q   <= rfd_in_d;
            dav_out_q  <= dav_out_d;
            data_out_q <= data_out_d;
            rem_out_q  <= rem_out_d;
            count_q    <= count_d;
        end
    end

    // Working datapath registers carry no meaning outside S1, so no reset.
    always_ff @(posedge clock) begin
        rad_q  <= rad_d;
        rem_q  <= rem_d;
        root_q <= root_d;
    end

    assign bus.rfd_in   = rfd_in_q;
    assign bus.dav_out_ = dav_out_q;
    assign bus.data_out = data_out_q;
    assign bus.rem_out  = rem_out_q;
endmodule

// File: tb/tb_area_sqrt.sv
// Self-checking bench for area_sqrt: directed corner values, random areas
// against an arithmetic square-root model, and handshake/reset scenarios.
module tb_area_sqrt;
    localparam int W_IN  = 16;
    localparam int W_OUT = 8;
    localparam int LAT   = W_OUT + 1;

    logic clock;
    logic reset_;
    int   total;
    int   bad;

    area_sqrt_if #(.W_IN(W_IN), .W_OUT(W_OUT)) bus ();

    area_sqrt #(.W_IN(W_IN), .W_OUT(W_OUT)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int model_root(input int a);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one full transaction with the consumer ready; returns latency
    // (edges after capture until dav_out_ low) or -1 on timeout.
    task automatic run_txn(input logic [15:0] a, output logic [7:0] r,
                           output logic [8:0] m, output int lat);
        bus.data_in  = a;
        bus.dav_in_  = 1'b0;
        bus.rfd_out  = 1'b1;
        tick();
        bus.dav_in_  = 1'b1;
        bus.data_in  = 16'($urandom);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.dav_out_ == 1'b0) begin
                lat = k;
                break;
            end
        end
        r = bus.data_out;
        m = bus.rem_out;
        bus.rfd_out = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_      = 1'b0;
        bus.data_in = '0;
        bus.dav_in_ = 1'b1;
        bus.rfd_out = 1'b0;
        tick();
        tick();
        reset_ = 1'b1;
        total++;
        if (bus.rfd_in !== 1'b1 || bus.dav_out_ !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctl: rfd_in=%b dav_out_=%b required 1/1", bus.rfd_in, bus.dav_out_);
        end
        total++;
        if (bus.data_out !== 8'd0 || bus.rem_out !== 9'd0) begin
            bad++;
            $display("FAIL reset_data: data_out=%0d rem_out=%0d required 0/0", bus.data_out, bus.rem_out);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [6] = '{16'd0, 16'd65535, 16'd144, 16'd200, 16'd1, 16'd3};
        logic [7:0]  vr [6] = '{8'd0, 8'd255, 8'd12, 8'd14, 8'd1, 8'd1};
        logic [8:0]  vm [6] = '{9'd0, 9'd510, 9'd0, 9'd4, 9'd0, 9'd2};
        logic [7:0]  r;
        logic [8:0]  m;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_txn(va[i], r, m, lat);
            total++;
            if (lat !== LAT) begin
                bad++;
                $display("FAIL dir_latency[%0d]: got %0d required %0d", va[i], lat, LAT);
            end
            total++;
            if (r !== vr[i] || m !== vm[i]) begin
                bad++;
                $display("FAIL dir_result[%0d]: got %0d/%0d required %0d/%0d", va[i], r, m, vr[i], vm[i]);
            end
            total++;
            if (bus.rfd_in !== 1'b1 || bus.dav_out_ !== 1'b1) begin
                bad++;
                $display("FAIL dir_idle[%0d]: rfd_in=%b dav_out_=%b required 1/1", va[i], bus.rfd_in, bus.dav_out_);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [7:0]  r;
        logic [8:0]  m;
        int          lat, er, em;
        for (int i = 0; i < 25; i++) begin
            a  = 16'($urandom);
            er = model_root(int'(a));
            em = int'(a) - er * er;
            run_txn(a, r, m, lat);
            total++;
            if (lat !== LAT || int'(r) != er || int'(m) != em) begin
                bad++;
                $display("FAIL rand[%0d]: got %0d/%0d lat %0d required %0d/%0d lat %0d", a, r, m, lat, er, em, LAT);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a;
        int          er, em;
        logic        ok;
        a  = 16'd50000;
        er = model_root(int'(a));
        em = int'(a) - er * er;
        bus.data_in = a;
        bus.dav_in_ = 1'b0;
        bus.rfd_out = 1'b0;
        tick();
        bus.dav_in_ = 1'b1;
        total++;
        if (bus.rfd_in !== 1'b0) begin
            bad++;
            $display("FAIL bp_capture: rfd_in=%b required 0", bus.rfd_in);
        end
        repeat (W_OUT) tick();
        total++;
        if (int'(bus.data_out) != er || int'(bus.rem_out) != em) begin
            bad++;
            $display("FAIL bp_result: got %0d/%0d required %0d/%0d", bus.data_out, bus.rem_out, er, em);
        end
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.dav_out_ !== 1'b1 || int'(bus.data_out) != er) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_hold: dav_out_=%b data_out=%0d required 1/%0d", bus.dav_out_, bus.data_out, er);
        end
        bus.rfd_out = 1'b1;
        tick();
        total++;
        if (bus.dav_out_ !== 1'b0 || int'(bus.rem_out) != em) begin
            bad++;
            $display("FAIL bp_release: dav_out_=%b rem_out=%0d required 0/%0d", bus.dav_out_, bus.rem_out, em);
        end
        bus.rfd_out = 1'b0;
        tick();
    endtask

    task automatic test_hold_dav();
        logic ok;
        bus.data_in = 16'd144;
        bus.dav_in_ = 1'b0;
        bus.rfd_out = 1'b1;
        tick();
        repeat (LAT) tick();
        total++;
        if (bus.dav_out_ !== 1'b0 || bus.data_out !== 8'd12) begin
            bad++;
            $display("FAIL hold_done: dav_out_=%b data_out=%0d required 0/12", bus.dav_out_, bus.data_out);
        end
        bus.rfd_out = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.rfd_in !== 1'b0 || bus.dav_out_ !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hold_stay: rfd_in=%b dav_out_=%b required 0/0", bus.rfd_in, bus.dav_out_);
        end
        bus.dav_in_ = 1'b1;
        tick();
        total++;
        if (bus.rfd_in !== 1'b1 || bus.dav_out_ !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: rfd_in=%b dav_out_=%b required 1/1", bus.rfd_in, bus.dav_out_);
        end
        tick();
        total++;
        if (bus.rfd_in !== 1'b1 || bus.data_out !== 8'd12) begin
            bad++;
            $display("FAIL hold_idle: rfd_in=%b data_out=%0d required 1/12", bus.rfd_in, bus.data_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        logic [8:0] m;
        int         lat;
        bus.data_in = 16'd40000;
        bus.dav_in_ = 1'b0;
        bus.rfd_out = 1'b1;
        tick();
        bus.dav_in_ = 1'b1;
        repeat (3) tick();
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;
        total++;
        if (bus.rfd_in !== 1'b1 || bus.dav_out_ !== 1'b1 || bus.data_out !== 8'd0 || bus.rem_out !== 9'd0) begin
            bad++;
            $display("FAIL rst_mid: rfd_in=%b dav_out_=%b out=%0d/%0d required 1/1 0/0",
                     bus.rfd_in, bus.dav_out_, bus.data_out, bus.rem_out);
        end
        repeat (LAT + 2) tick();
        total++;
        if (bus.dav_out_ !== 1'b1 || bus.data_out !== 8'd0) begin
            bad++;
            $display("FAIL rst_no_partial: dav_out_=%b data_out=%0d required 1/0", bus.dav_out_, bus.data_out);
        end
        bus.rfd_out = 1'b0;
        tick();
        run_txn(16'd40000, r, m, lat);
        total++;
        if (lat !== LAT || r !== 8'd200 || m !== 9'd0) begin
            bad++;
            $display("FAIL rst_after: got %0d/%0d lat %0d required 200/0 lat %0d", r, m, lat, LAT);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_hold_dav();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
